// File: rtl/t02_mem_arbiter.sv
// N-channel arbiter in front of a single shared RAM port with a busy handshake.
// Fixed-priority or round-robin grant, latched request, optional stuck-RAM watchdog.
module t02_mem_arbiter #(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RR_EN   = 0,
   parameter int unsigned TIMEOUT = 255,
   localparam int unsigned ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [NUM_CH-1:0]        req_ren,
   input  logic [NUM_CH-1:0]        req_wen,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata,
   output logic [NUM_CH-1:0]        req_ready,
   output logic                     req_err,
   output logic [DATA_W-1:0]        req_rdata,
   output logic [ID_W-1:0]          grant_id,
   output logic                     ram_ren,
   output logic                     ram_wen,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_wdata,
   input  logic [DATA_W-1:0]        ram_rdata,
   input  logic                     ram_busy
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [NUM_CH-1:0]   active;
   logic                any_active;
   logic [ID_W-1:0]     win_id;
   int unsigned         rr_idx;

   assign active     = req_ren | req_wen;
   assign any_active = |active;

   // Scan from the far end so the last hit (lowest index / nearest to pointer) wins.
   always_comb begin
      win_id = '0;
      rr_idx = 0;
      if (RR_EN == 0) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (active[i]) win_id = ID_W'(i);
         end
      end else begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            rr_idx = (int'(rr_ptr_q) + k) % NUM_CH;
            if (active[rr_idx]) win_id = ID_W'(rr_idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (any_active) begin
               grant_d = win_id;
               addr_d  = req_addr[win_id*ADDR_W +: ADDR_W];
               wdata_d = req_wdata[win_id*DATA_W +: DATA_W];
               // Read wins when both strobes are set.
               wr_d    = ~req_ren[win_id];
               state_d = StBusy;
            end
         end
         StBusy: begin
            cnt_d = cnt_q + 1'b1;
            if (!ram_busy) begin
               rdata_d = wr_q ? '0 : ram_rdata;
               state_d = StResp;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StResp;
            end
         end
         StResp: begin
            state_d  = StIdle;
            cnt_d    = '0;
            err_d    = 1'b0;
            rr_ptr_d = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      ram_ren   = (state_q == StBusy) && !wr_q;
      ram_wen   = (state_q == StBusy) && wr_q;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      req_ready = '0;
      if (state_q == StResp) req_ready[grant_q] = 1'b1;
      req_err   = (state_q == StResp) && err_q;
      req_rdata = rdata_q;
      grant_id  = grant_q;
   end

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Directed bench for t02_mem_arbiter: a fixed-priority 2-channel instance with an
// 8-cycle watchdog and a 3-channel round-robin instance.
module tb_t02_mem_arbiter;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   // Instance A: NUM_CH=2, fixed priority, TIMEOUT=8
   logic [1:0]  req_ren_a, req_wen_a, req_ready_a;
   logic [63:0] req_addr_a, req_wdata_a;
   logic        req_err_a, ram_ren_a, ram_wen_a, ram_busy_a;
   logic [31:0] req_rdata_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
   logic [0:0]  grant_id_a;

   // Instance B: NUM_CH=3, round-robin
   logic [2:0]  req_ren_b, req_wen_b, req_ready_b;
   logic [95:0] req_addr_b, req_wdata_b;
   logic        req_err_b, ram_ren_b, ram_wen_b, ram_busy_b;
   logic [31:0] req_rdata_b, ram_addr_b, ram_wdata_b, ram_rdata_b;
   logic [1:0]  grant_id_b;

   t02_mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(8)) dut_a (
      .CLK(CLK), .nRST(nRST),
      .req_ren(req_ren_a), .req_wen(req_wen_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
      .req_ready(req_ready_a), .req_err(req_err_a), .req_rdata(req_rdata_a),
      .grant_id(grant_id_a), .ram_ren(ram_ren_a), .ram_wen(ram_wen_a), .ram_addr(ram_addr_a),
      .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a), .ram_busy(ram_busy_a)
   );

   t02_mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(255)) dut_b (
      .CLK(CLK), .nRST(nRST),
      .req_ren(req_ren_b), .req_wen(req_wen_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .req_ready(req_ready_b), .req_err(req_err_b), .req_rdata(req_rdata_b),
      .grant_id(grant_id_b), .ram_ren(ram_ren_b), .ram_wen(ram_wen_b), .ram_addr(ram_addr_b),
      .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b), .ram_busy(ram_busy_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   int          busy_cycles;
   logic        seen_ready;
   int unsigned exp_ch;

   initial begin
      nRST = 1'b0;
      req_ren_a = '0; req_wen_a = '0; req_addr_a = '0; req_wdata_a = '0;
      ram_rdata_a = '0; ram_busy_a = 1'b0;
      req_ren_b = '0; req_wen_b = '0; req_addr_b = '0; req_wdata_b = '0;
      ram_rdata_b = '0; ram_busy_b = 1'b0;
      #2;
      check("rst_ram_ren", ram_ren_a, 0);
      check("rst_ram_wen", ram_wen_a, 0);
      check("rst_ready", req_ready_a, 0);
      check("rst_err", req_err_a, 0);
      check("rst_grant", grant_id_a, 0);
      check("rst_addr", ram_addr_a, 0);
      check("rst_rdata", req_rdata_a, 0);
      #20 nRST = 1'b1;
      tick();

      // Round-robin: all three channels request continuously
      for (int i = 0; i < 3; i++) req_addr_b[i*32 +: 32] = 32'h1000 + i;
      req_ren_b = 3'b111;
      tick();
      for (int k = 0; k < 4; k++) begin
         exp_ch = k % 3;
         check("rr_grant", grant_id_b, exp_ch);
         check("rr_addr", ram_addr_b, 32'h1000 + exp_ch);
         check("rr_ren", ram_ren_b, 1);
         tick();
         check("rr_ready", req_ready_b, 3'b001 << exp_ch);
         tick();
         check("rr_idle_ready", req_ready_b, 0);
         tick();
      end
      req_ren_b = '0;
      tick(); tick();

      // Fixed priority: ch0 and ch1 both read
      req_addr_a[0 +: 32]  = 32'h100;
      req_addr_a[32 +: 32] = 32'h200;
      ram_rdata_a = 32'hDEADBEEF;
      req_ren_a = 2'b11;
      tick();
      check("fp_c1_ren", ram_ren_a, 1);
      check("fp_c1_addr", ram_addr_a, 32'h100);
      check("fp_c1_grant", grant_id_a, 0);
      tick();
      check("fp_c2_ready", req_ready_a, 2'b01);
      check("fp_c2_rdata", req_rdata_a, 32'hDEADBEEF);
      req_ren_a = 2'b10;
      tick();
      check("fp_c3_ready", req_ready_a, 0);
      check("fp_c3_ren", ram_ren_a, 0);
      tick();
      check("fp_c4_addr", ram_addr_a, 32'h200);
      check("fp_c4_grant", grant_id_a, 1);
      tick();
      check("fp_c5_ready", req_ready_a, 2'b10);
      req_ren_a = '0;
      tick();
      check("fp_hold_ready", req_ready_a, 0);
      check("fp_hold_rdata", req_rdata_a, 32'hDEADBEEF);
      check("fp_hold_grant", grant_id_a, 1);

      // Write with stall; requester drops its inputs once granted
      req_wen_a = 2'b10;
      req_addr_a[32 +: 32]  = 32'h40;
      req_wdata_a[32 +: 32] = 32'hCAFEF00D;
      ram_busy_a = 1'b1;
      tick();
      req_wen_a = '0;
      req_addr_a[32 +: 32]  = 32'hFFFF;
      req_wdata_a[32 +: 32] = 32'h0;
      for (int b = 0; b < 5; b++) begin
         if (b == 4) ram_busy_a = 1'b0;
         check("wr_wen", ram_wen_a, 1);
         check("wr_ren", ram_ren_a, 0);
         check("wr_addr", ram_addr_a, 32'h40);
         check("wr_wdata", ram_wdata_a, 32'hCAFEF00D);
         check("wr_no_ready", req_ready_a, 0);
         tick();
      end
      check("wr_ready", req_ready_a, 2'b10);
      check("wr_err", req_err_a, 0);
      check("wr_rdata", req_rdata_a, 0);
      tick();

      // Watchdog: RAM stuck busy
      req_ren_a = 2'b01;
      req_addr_a[0 +: 32] = 32'h55;
      ram_rdata_a = 32'h11111111;
      ram_busy_a = 1'b1;
      tick();
      busy_cycles = 0;
      for (int i = 0; i < 20 && ram_ren_a; i++) begin
         busy_cycles++;
         tick();
      end
      check("to_busy_cycles", busy_cycles, 8);
      check("to_ready", req_ready_a, 2'b01);
      check("to_err", req_err_a, 1);
      check("to_rdata", req_rdata_a, 0);
      req_ren_a = 2'b10;
      req_addr_a[32 +: 32] = 32'h60;
      ram_busy_a = 1'b0;
      ram_rdata_a = 32'h12345678;
      tick();
      check("to_idle_err", req_err_a, 0);
      check("to_idle_ready", req_ready_a, 0);
      tick();
      check("to_next_grant", grant_id_a, 1);
      check("to_next_addr", ram_addr_a, 32'h60);
      tick();
      check("to_next_ready", req_ready_a, 2'b10);
      check("to_next_err", req_err_a, 0);
      check("to_next_rdata", req_rdata_a, 32'h12345678);
      req_ren_a = '0;
      tick();

      // ren and wen together: read wins
      req_ren_a = 2'b01;
      req_wen_a = 2'b01;
      req_addr_a[0 +: 32] = 32'h77;
      ram_rdata_a = 32'hA5A5A5A5;
      tick();
      check("rw_ren", ram_ren_a, 1);
      check("rw_wen", ram_wen_a, 0);
      check("rw_addr", ram_addr_a, 32'h77);
      tick();
      check("rw_ready", req_ready_a, 2'b01);
      check("rw_rdata", req_rdata_a, 32'hA5A5A5A5);
      req_ren_a = '0;
      req_wen_a = '0;
      tick();

      // Asynchronous reset in the middle of a read
      req_ren_a = 2'b01;
      req_addr_a[0 +: 32] = 32'h88;
      ram_busy_a = 1'b1;
      tick();
      check("mr_ren_before", ram_ren_a, 1);
      #2 nRST = 1'b0;
      #1;
      check("mr_ren", ram_ren_a, 0);
      check("mr_ready", req_ready_a, 0);
      check("mr_addr", ram_addr_a, 0);
      check("mr_rdata", req_rdata_a, 0);
      req_ren_a = '0;
      ram_busy_a = 1'b0;
      #2 nRST = 1'b1;
      seen_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen_ready = seen_ready | (|req_ready_a) | ram_ren_a;
      end
      check("mr_no_pulse", seen_ready, 0);
      req_ren_a = 2'b10;
      req_addr_a[32 +: 32] = 32'h99;
      tick();
      check("mr_regrant", grant_id_a, 1);
      check("mr_regrant_ren", ram_ren_a, 1);
      tick();
      check("mr_regrant_ready", req_ready_a, 2'b10);
      req_ren_a = '0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/t02_mem_arbiter.md
Name: t02_mem_arbiter

Overview:
- Parametrised N-channel arbiter between core memory requesters (instruction fetch, data load/store, future DMA) and the single shared RAM port with its busy handshake.
- Latches the winning request's address, write data and operation.
- Holds the RAM strobes steady until the RAM drops busy, then returns read data and a one-cycle ready pulse to the granted channel.
- Supports fixed-priority or round-robin arbitration, and a watchdog timeout on a stuck RAM.

Parameters:
- NUM_CH, 2, number of requester channels (channel 0 = highest fixed priority).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RR_EN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 255, maximum BUSY-state cycles before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- req_ren  in  NUM_CH  per-channel read request, held until that channel's req_ready.
- req_wen  in  NUM_CH  per-channel write request, held until that channel's req_ready.
- req_addr  in  NUM_CH*ADDR_W  flattened addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  flattened write data, same packing.
- req_ready  out  NUM_CH  one-hot, one-cycle completion pulse.
- req_err  out  1  high with req_ready when the transaction timed out.
- req_rdata  out  DATA_W  read data, valid during the req_ready cycle.
- grant_id  out  $clog2(NUM_CH) (min 1)  index of the channel currently or last granted.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- ram_busy  in  1  RAM busy; the transaction is complete when it is low.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0, latched registers 0. Reset mid-transaction aborts it; no ready pulse is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - RAM strobes low.
  - A channel is active if req_ren|req_wen.
  - If any channel is active, choose a winner and latch its addr, wdata and operation into registers, set grant_id, then go to BUSY.
  - Read wins if a channel asserts both ren and wen.
  - Fixed priority: lowest active index wins.
  - Round-robin: first active index at or after the pointer, wrapping modulo NUM_CH.
- BUSY:
  - ram_addr and ram_wdata come from the latched registers and stay stable for the whole state.
  - Exactly one of ram_ren/ram_wen is high, per the latched operation.
  - Counter increments every cycle.
  - On a clock edge with ram_busy=0: capture ram_rdata (reads only; writes capture 0), go to RESP.
  - Else, if TIMEOUT!=0 and the counter has reached TIMEOUT-1: set the err flag, rdata=0, go to RESP.
- RESP:
  - RAM strobes low.
  - req_ready[grant_id]=1; req_err=err flag; req_rdata=captured value.
  - Next state is IDLE.
  - Round-robin pointer becomes grant_id+1, wrapping to 0 after NUM_CH-1.
  - Counter and err flag clear.
- Latency: request first seen at edge N; BUSY during cycle N+1; ready no earlier than cycle N+2. Minimum 3 cycles per transaction, back-to-back.
- Requests are not sampled outside IDLE. A requester dropping its request while granted does not abort the transaction; it still completes and pulses ready.
- A requester must drop its request the cycle after ready, or it will be re-granted.
- req_rdata and grant_id hold their last values outside RESP. req_ready is 0 outside RESP.
- Counter width is $clog2(TIMEOUT+1), with saturation-free compare.

Test Plan:
- Fixed priority (RR_EN=0, NUM_CH=2): ch0 and ch1 both read at cycle 0 (addr 0x100 and 0x200), ram_busy held 0, ram_rdata=0xDEADBEEF → ram_ren with ram_addr=0x100 in cycle 1; req_ready=2'b01 with rdata 0xDEADBEEF in cycle 2; ch1 is served next with ram_addr=0x200 and req_ready=2'b10 in cycle 5.
- Round-robin (RR_EN=1, NUM_CH=3): all three channels request continuously → grants go 0,1,2,0 with ready pulses every 3 cycles.
- Write with stall: ch1 writes 0xCAFEF00D to 0x40, ram_busy high for 4 BUSY cycles → ram_wen, ram_addr and ram_wdata stable all 4 cycles; ready in the cycle after busy falls; req_err=0.
- Timeout (TIMEOUT=8): ram_busy stuck at 1 → exactly 8 BUSY cycles, then req_ready and req_err=1 with rdata=0, then return to IDLE and a new grant succeeds.
- Reset mid-BUSY: nRST pulsed low during a read → strobes and ready are 0 immediately (asynchronous reset); no ready pulse after release; state is IDLE.
- Both ren and wen on ch0 → ram_ren=1, ram_wen=0; rdata is returned.
